// File: rtl/uart_receive.sv
// rtl/uart_receive.sv - 8N1-style UART receiver with oversampled start validation and error flags
module uart_receive #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_baud,
  input  logic       rxd,
  input  logic       rx_read_en,
  output logic [7:0] rx_data,
  output logic       rda,
  output logic       framing_err,
  output logic       overrun_err,
  output logic       rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic            rxd_meta_q, rxd_meta_d;
  logic            rxd_s_q, rxd_s_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rda_q, rda_d;
  logic            framing_err_q, framing_err_d;
  logic            overrun_err_q, overrun_err_d;
  logic            frame_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (rx_baud) begin
      case (state_q)
        IDLE:    if (!rxd_s_q) state_d = START;
        START:   if (tick_cnt_q == TICK_MID) state_d = rxd_s_q ? IDLE : DATA;
        DATA:    if (tick_cnt_q == TICK_LAST && bit_idx_q == BIT_LAST) state_d = STOP;
        STOP:    if (tick_cnt_q == TICK_LAST) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    rx_busy = (state_q != IDLE);
  end

  always_comb begin
    rxd_meta_d    = rxd;
    rxd_s_d       = rxd_meta_q;
    tick_cnt_d    = tick_cnt_q;
    bit_idx_d     = bit_idx_q;
    shreg_d       = shreg_q;
    rx_data_d     = rx_data_q;
    rda_d         = rda_q;
    framing_err_d = framing_err_q;
    overrun_err_d = overrun_err_q;
    frame_done    = rx_baud && (state_q == STOP) && (tick_cnt_q == TICK_LAST);

    if (rx_baud) begin
      case (state_q)
        IDLE: tick_cnt_d = '0;
        START: begin
          tick_cnt_d = (tick_cnt_q == TICK_MID) ? '0 : tick_cnt_q + 1'b1;
          bit_idx_d  = '0;
        end
        DATA: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            bit_idx_d  = bit_idx_q + 4'd1;
            shreg_d    = {rxd_s_q, shreg_q[7:1]};
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        STOP:    tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
        default: tick_cnt_d = '0;
      endcase
    end

    // A completing frame takes priority over a same-cycle read strobe.
    if (frame_done) begin
      rx_data_d     = shreg_q >> (8 - DATA_BITS);
      rda_d         = 1'b1;
      framing_err_d = ~rxd_s_q;
      overrun_err_d = rx_read_en ? 1'b0 : (overrun_err_q | rda_q);
    end else if (rx_read_en) begin
      rda_d         = 1'b0;
      framing_err_d = 1'b0;
      overrun_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q    <= 1'b1;
      rxd_s_q       <= 1'b1;
      tick_cnt_q    <= '0;
      bit_idx_q     <= '0;
      shreg_q       <= '0;
      rx_data_q     <= '0;
      rda_q         <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      rxd_meta_q    <= rxd_meta_d;
      rxd_s_q       <= rxd_s_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_idx_q     <= bit_idx_d;
      shreg_q       <= shreg_d;
      rx_data_q     <= rx_data_d;
      rda_q         <= rda_d;
      framing_err_q <= framing_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rda         = rda_q;
  assign framing_err = framing_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_receive.sv
// tb/tb_uart_receive.sv - directed testbench for uart_receive
module tb_uart_receive;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_baud;
  logic       rxd;
  logic       rx_read_en;
  logic [7:0] rx_data;
  logic       rda;
  logic       framing_err;
  logic       overrun_err;
  logic       rx_busy;

  int checks   = 0;
  int failures = 0;
  int bc       = 0;
  int rise;
  int rise81;
  int busy_cnt;

  uart_receive #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_baud     (rx_baud),
    .rxd         (rxd),
    .rx_read_en  (rx_read_en),
    .rx_data     (rx_data),
    .rda         (rda),
    .framing_err (framing_err),
    .overrun_err (overrun_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  // rx_baud high one clk in four: 16 ticks per 64-clk bit
  initial begin
    rx_baud = 1'b0;
    forever begin
      @(negedge clk);
      rx_baud = (bc == 3);
      bc = (bc + 1) % 4;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic align();
    @(posedge clk);
    while (bc != 0) @(posedge clk);
  endtask

  task automatic read_pulse();
    @(negedge clk);
    rx_read_en = 1'b1;
    @(negedge clk);
    rx_read_en = 1'b0;
  endtask

  // Drives one frame at 64 clk/bit; read_at selects the clk (frame-relative) of a read strobe.
  task automatic send_frame(input logic [7:0] data, input logic stop_val,
                            input int read_at, output int rise_j);
    logic prev;
    int   bit_no;
    rise_j = -1;
    align();
    prev = rda;
    for (int j = 0; j < 640; j++) begin
      @(negedge clk);
      if (!prev && rda && rise_j < 0) rise_j = j;
      prev   = rda;
      bit_no = j / 64;
      if (bit_no == 0)      rxd = 1'b0;
      else if (bit_no == 9) rxd = stop_val;
      else                  rxd = data[bit_no-1];
      rx_read_en = (j == read_at);
    end
    @(negedge clk);
    rxd        = 1'b1;
    rx_read_en = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    rxd        = 1'b1;
    rx_read_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rda", rda, 0);
    check("reset_framing", framing_err, 0);
    check("reset_overrun", overrun_err, 0);
    check("reset_busy", rx_busy, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_busy", rx_busy, 0);

    // 1: single frame and read
    send_frame(8'hA5, 1'b1, -1, rise);
    check("t1_latency_ok", (rise >= 600 && rise <= 625), 1);
    check("t1_rda", rda, 1);
    check("t1_data", rx_data, 8'hA5);
    check("t1_framing", framing_err, 0);
    check("t1_overrun", overrun_err, 0);
    check("t1_busy", rx_busy, 0);
    read_pulse();
    check("t1_rda_cleared", rda, 0);
    check("t1_data_held", rx_data, 8'hA5);

    // 2: back-to-back without reading gives overrun
    send_frame(8'h3C, 1'b1, -1, rise);
    check("t2_data1", rx_data, 8'h3C);
    check("t2_overrun1", overrun_err, 0);
    send_frame(8'hC3, 1'b1, -1, rise);
    check("t2_data2", rx_data, 8'hC3);
    check("t2_rda", rda, 1);
    check("t2_overrun2", overrun_err, 1);
    check("t2_framing", framing_err, 0);
    read_pulse();
    check("t2_rda_clr", rda, 0);
    check("t2_overrun_clr", overrun_err, 0);
    check("t2_framing_clr", framing_err, 0);

    // 3: low stop bit
    send_frame(8'h55, 1'b0, -1, rise);
    check("t3_rda", rda, 1);
    check("t3_data", rx_data, 8'h55);
    check("t3_framing", framing_err, 1);
    repeat (200) @(negedge clk);
    check("t3_idle_busy", rx_busy, 0);
    check("t3_idle_rda", rda, 1);
    check("t3_idle_data", rx_data, 8'h55);
    check("t3_idle_framing", framing_err, 1);
    read_pulse();
    check("t3_framing_clr", framing_err, 0);
    check("t3_rda_clr", rda, 0);

    // 4: short glitch, three ticks low
    align();
    busy_cnt = 0;
    for (int j = 0; j < 80; j++) begin
      @(negedge clk);
      if (rx_busy) busy_cnt++;
      rxd = (j < 12) ? 1'b0 : 1'b1;
    end
    check("t4_busy_span_ok", (busy_cnt >= 30 && busy_cnt <= 34), 1);
    check("t4_rda", rda, 0);
    check("t4_busy_end", rx_busy, 0);

    // 5: reset mid-DATA of 0xFF
    align();
    for (int j = 0; j < 64 + 3 * 64 + 20; j++) begin
      @(negedge clk);
      rxd = (j < 64) ? 1'b0 : 1'b1;
    end
    check("t5_busy_before", rx_busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_data", rx_data, 8'h00);
    check("t5_rst_rda", rda, 0);
    check("t5_rst_framing", framing_err, 0);
    check("t5_rst_overrun", overrun_err, 0);
    check("t5_rst_busy", rx_busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (500) @(negedge clk);
    check("t5_post_busy", rx_busy, 0);
    check("t5_post_rda", rda, 0);
    send_frame(8'h81, 1'b1, -1, rise81);
    check("t5_latency_ok", (rise81 >= 600 && rise81 <= 625), 1);
    check("t5_data", rx_data, 8'h81);
    check("t5_rda", rda, 1);
    check("t5_framing", framing_err, 0);
    check("t5_overrun", overrun_err, 0);

    // 6: read strobe lands on the completion clk of 0x7E
    send_frame(8'h7E, 1'b1, rise81 - 1, rise);
    check("t6_data", rx_data, 8'h7E);
    check("t6_rda", rda, 1);
    check("t6_overrun", overrun_err, 0);
    check("t6_framing", framing_err, 0);
    read_pulse();
    check("t6_rda_clr", rda, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
